// File: rtl/permutation_sequencer.sv
// Round sequencer for a 320-bit permutation datapath.
// Walks LOAD, then rounds start..11, then a DONE pulse.
module permutation_sequencer (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       load_state_o,
  output logic       round_en_o,
  output logic [3:0] round_o,
  output logic       last_round_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic [3:0] start_idx;

  // First round index for the captured mode; reserved mode runs as pa
  always_comb begin
    start_idx = 4'd0;
    case (mode_q)
      2'b01:   start_idx = 4'd6;
      2'b10:   start_idx = 4'd4;
      default: start_idx = 4'd0;
    endcase
  end

  // State, round counter and captured mode registers
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; abort outranks both start and round progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (start_i && !abort_i) begin
          state_d = LOAD;
          mode_d  = mode_i;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ROUND;
          cnt_d   = start_idx;
        end
      end
      ROUND: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decoded purely from registered state and counter
  always_comb begin
    ready_o      = (state_q == IDLE);
    load_state_o = (state_q == LOAD);
    round_en_o   = (state_q == ROUND);
    round_o      = (state_q == ROUND) ? cnt_q : 4'd0;
    last_round_o = (state_q == ROUND) && (cnt_q == LAST_IDX);
    done_o       = (state_q == DONE);
  end

endmodule

// File: tb/tb_permutation_sequencer.sv
// Directed bench for permutation_sequencer.
// Expected round sequences are hand-derived per mode.
module tb_permutation_sequencer;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic       abort_i = 1'b0;
  logic       ready_o;
  logic       load_state_o;
  logic       round_en_o;
  logic [3:0] round_o;
  logic       last_round_o;
  logic       done_o;

  int n_vec = 0;
  int n_err = 0;

  permutation_sequencer dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .abort_i      (abort_i),
    .ready_o      (ready_o),
    .load_state_o (load_state_o),
    .round_en_o   (round_en_o),
    .round_o      (round_o),
    .last_round_o (last_round_o),
    .done_o       (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".ready"}, int'(ready_o), 1);
    check({tag, ".load"}, int'(load_state_o), 0);
    check({tag, ".en"}, int'(round_en_o), 0);
    check({tag, ".round"}, int'(round_o), 0);
    check({tag, ".last"}, int'(last_round_o), 0);
    check({tag, ".done"}, int'(done_o), 0);
  endtask

  task automatic run_op(input logic [1:0] m, input int n,
                        input int s, input bit toggle);
    mode_i  = m;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    if (toggle) mode_i = ~m;
    check("load", int'(load_state_o), 1);
    check("busy", int'(ready_o), 0);
    check("load_en", int'(round_en_o), 0);
    for (int i = 0; i < n; i++) begin
      step();
      if (toggle) mode_i = mode_i + 2'd1;
      check("en", int'(round_en_o), 1);
      check("rnd", int'(round_o), s + i);
      check("last", int'(last_round_o), (i == n - 1) ? 1 : 0);
      check("early_done", int'(done_o), 0);
      check("rnd_busy", int'(ready_o), 0);
    end
    step();
    check("done", int'(done_o), 1);
    check("done_rnd", int'(round_o), 0);
    check("done_busy", int'(ready_o), 0);
    step();
    chk_idle("post");
    mode_i = 2'b00;
  endtask

  initial begin
    int loads;
    int dones;
    int last_c;
    int first_c;

    #3;
    chk_idle("reset");
    #10;
    resetb_i = 1'b1;
    step();
    chk_idle("idle");

    // pa, pb, pb8, reserved, and pa with mode_i wiggling
    run_op(2'b00, 12, 0, 1'b0);
    run_op(2'b01, 6, 6, 1'b0);
    run_op(2'b10, 8, 4, 1'b0);
    run_op(2'b11, 12, 0, 1'b0);
    run_op(2'b00, 12, 0, 1'b1);
    run_op(2'b01, 6, 6, 1'b1);

    // abort in IDLE blocks a concurrent start
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk_idle("idle_abort");

    // start held high: loads every 9 cycles for pb
    mode_i  = 2'b01;
    start_i = 1'b1;
    loads   = 0;
    dones   = 0;
    last_c  = 0;
    first_c = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (load_state_o) begin
        loads++;
        if (loads == 1) first_c = c;
        else check("period", c - last_c, 9);
        last_c = c;
      end
      if (done_o) dones++;
    end
    start_i = 1'b0;
    check("first_load", first_c, 1);
    check("n_loads", loads, 3);
    check("n_dones", dones, 2);
    step();
    check("held_done", int'(done_o), 1);
    step();
    chk_idle("held_end");

    // abort at round 3 of pa
    mode_i  = 2'b00;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_at", int'(round_o), 3);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_idle("aborted");
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done_o) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(2'b00, 12, 0, 1'b0);

    // async reset at round 8 of pa
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("rst_at", int'(round_o), 8);
    #2;
    resetb_i = 1'b0;
    #1;
    chk_idle("rst_async");
    @(posedge clock_i);
    #3;
    resetb_i = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done_o) dones++;
      if (!ready_o) dones += 100;
    end
    check("rst_no_done", dones, 0);
    run_op(2'b10, 8, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/permutation_sequencer.md
PERMUTATION_SEQUENCER -- requirements
Module: permutation_sequencer

Interface
REQ-001 The block SHALL have the port clock_i, input, 1 bit: rising-edge clock for all sequential logic.
REQ-002 The block SHALL have the port resetb_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port start_i, input, 1 bit: permutation request, sampled only while ready_o=1.
REQ-004 The block SHALL have the port mode_i, input, 2 bits: round count select; 00 = pa, 12 rounds; 01 = pb, 6 rounds; 10 = pb8, 8 rounds; 11 = reserved, treated as 00.
REQ-005 The block SHALL have the port abort_i, input, 1 bit: synchronous cancel of the current permutation.
REQ-006 The block SHALL have the port ready_o, output, 1 bit: block idle and able to accept start_i.
REQ-007 The block SHALL have the port load_state_o, output, 1 bit: one-cycle strobe to the datapath to load the 320-bit state register.
REQ-008 The block SHALL have the port round_en_o, output, 1 bit: the datapath applies one permutation round this cycle.
REQ-009 The block SHALL have the port round_o, output, 4 bits: round-constant index of the round applied this cycle.
REQ-010 The block SHALL have the port last_round_o, output, 1 bit: the current round is the final round of the permutation.
REQ-011 The block SHALL have the port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The block SHALL implement an FSM with the states IDLE, LOAD, ROUND and DONE.
REQ-013 In IDLE, ready_o SHALL be 1 and all other outputs SHALL be 0; ready_o SHALL be 0 in every other state.
REQ-014 IDLE SHALL go to LOAD on the next edge when start_i=1 and abort_i=0; mode_i SHALL be captured into an internal register on that edge.
REQ-015 LOAD SHALL last exactly 1 cycle with load_state_o=1, then SHALL go to ROUND.
REQ-016 Start index: pa = 0, pb = 6, pb8 = 4, taken from the captured mode; changes on mode_i after capture SHALL have no effect.
REQ-017 ROUND SHALL last N cycles (pa 12, pb 6, pb8 8) with round_en_o=1 every cycle.
REQ-018 round_o SHALL equal the start index in the first ROUND cycle and SHALL increment by 1 each cycle, ending at 11 in every mode.
REQ-019 last_round_o SHALL be 1 exactly when in ROUND and round_o=11.
REQ-020 round_o SHALL never wrap past 11 and SHALL be 0 outside ROUND.
REQ-021 After the ROUND cycle with round_o=11, the FSM SHALL go to DONE.
REQ-022 DONE SHALL last 1 cycle with done_o=1, then SHALL go to IDLE.
REQ-023 Total latency from the start-accept edge to done_o high SHALL be N+2 cycles.
REQ-024 start_i SHALL be ignored whenever ready_o=0; no request queuing SHALL occur.
REQ-025 abort_i=1 in LOAD, ROUND or DONE SHALL force IDLE on the next edge; done_o SHALL NOT pulse for the aborted operation.
REQ-026 If abort_i=1 in IDLE, start_i SHALL be ignored that cycle (abort has priority over start).
REQ-027 Back-to-back operation: a new start SHALL be accepted on the first IDLE cycle after DONE, giving a minimum period of N+3 cycles.
REQ-028 All outputs SHALL be registered or decoded only from the state, counter and mode registers, with no combinational path from any input.

Reset
REQ-029 When resetb_i=0, the FSM SHALL be in IDLE, the round counter and captured mode SHALL be 0, and the outputs SHALL be ready_o=1 with all others 0, independent of clock_i.
REQ-030 Reset asserted mid-permutation SHALL discard the operation with no done_o pulse, and the first edge after reset release SHALL behave as IDLE.

Verification
REQ-031 The bench SHALL cover: mode 00, start pulse -> load_state_o 1 cycle, round_o 0..11 over 12 cycles with last_round_o at 11, done_o at cycle 14.
REQ-032 The bench SHALL cover: mode 01 then mode 10 -> round_o 6..11 (done at cycle 8), then 4..11 (done at cycle 10).
REQ-033 The bench SHALL cover: mode 11 -> behaviour identical to mode 00; mode_i toggled during ROUND -> sequence unchanged.
REQ-034 The bench SHALL cover: start_i held high continuously -> periods of exactly N+3 cycles, with no extra starts during busy.
REQ-035 The bench SHALL cover: abort_i at round_o=3 in pa -> IDLE next cycle, no done_o, and the next start runs fully.
REQ-036 The bench SHALL cover: resetb_i low at round_o=8 -> outputs immediately ready_o=1 with others 0, and no done_o after release.
